nios2_cpu_pio_irq_ctrl: RTL and testbench
=========================================

// Module: nios2_cpu_pio_irq_ctrl
// PURPOSE
//  Parametrised Avalon-MM slave: WIDTH-bit input PIO with per-bit edge/level
//  interrupt generation. Sits between external inputs (accel data-ready etc.)
//  and the Nios II IRQ line. Adds synchroniser, optional per-bit debounce,
//  per-bit rise/fall select, level mode and bit-wise write-1-to-clear capture.
// PARAMETERS
//  WIDTH           8            input bits, 1..32
//  SYNC_STAGES     2            synchroniser flops on in_port, 1..4
//  DEBOUNCE_CYCLES 0            stable cycles before accepting change; 0 = bypass
//  RISE_EN_RESET   {WIDTH{1'b1}} reset value of rise_en register
// PORTS
//  clk         in   1      system clock
//  reset_n     in   1      asynchronous active-low reset
//  address     in   3      register select (word)
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     registered read data
//  in_port     in   WIDTH  asynchronous external inputs
//  irq         out  1      interrupt request, active high
// BEHAVIOUR
//  - One clock, async active-low reset. Reset: readdata=0, all registers,
//    sync chain, debounce counters, stable/stable_d=0, rise_en=RISE_EN_RESET.
//  - Map (rd/wr): 0 data=stable (RO); 1 rise_en; 2 irq_mask; 3 edge_capture
//    (W1C); 4 fall_en; 5 level_en; 6 sync=raw synchronised input (RO); 7 reads 0.
//    Only bits [WIDTH-1:0] stored; upper readdata bits 0. Writes to RO ignored.
//  - Write = chipselect & ~write_n; takes effect on that clock edge.
//  - readdata <= mux(address) every clock, independent of chipselect:
//    1-cycle read latency.
//  - sync: SYNC_STAGES-flop chain per bit.
//  - Debounce (D=DEBOUNCE_CYCLES>0): per-bit counter. sync==stable -> cnt=0.
//    Otherwise cnt increments; when cnt==D-1, stable<=sync and cnt<=0.
//    A glitch shorter than D cycles never reaches stable. D=0: stable=sync.
//  - Edge: rise=stable&~stable_d&rise_en; fall=~stable&stable_d&fall_en;
//    stable_d <= stable each clock.
//  - Capture: per bit, set on rise|fall; cleared on address-3 write where the
//    writedata bit is 1. Set and clear in the same cycle -> set wins.
//  - Latency: in_port step sampled at edge N -> edge_capture set at edge
//    N+SYNC_STAGES+D. irq rises in the same cycle (combinational from regs).
//  - irq = |(((edge_capture & ~level_en) | (stable & level_en)) & irq_mask).
//    Level-mode bits ignore edge_capture for irq; capture still records edges.
//  - Input high through reset -> rising edge after release; captured if rise_en=1.
//  - Reset mid-debounce or mid-capture discards all state; no irq on release
//    until a new edge/level qualifies.
// TESTING
//  1 W=8,S=2,D=0: mask=0x01, in_port[0] 0->1 -> capture=0x01 and irq=1 two
//    edges later; write 0x01 to addr3 -> capture=0, irq=0.
//  2 fall_en=0x04, rise_en=0: in_port[2] 1->0 -> capture=0x04; 0->1 -> no set.
//  3 D=4: 3-cycle pulse on bit1 -> stable, capture unchanged. 4-cycle pulse ->
//    stable[1] high 4 clocks after sync, capture[1]=1.
//  4 Edge on bit3 in same cycle as W1C 0x08 -> capture[3] stays 1; W1C 0x01
//    with capture=0x09 -> 0x08.
//  5 level_en=0x10, mask=0x10: hold bit4 high -> irq=1 throughout; W1C 0x10
//    leaves irq=1; drop bit4 -> irq=0 after S+D+1 clocks.
//  6 Assert reset_n=0 mid-debounce with capture=0xFF -> all regs 0, irq=0
//    immediately; addr0 read after release returns 0 until input synchronises.

Source files
------------

// File: rtl/nios2_cpu_pio_irq_ctrl.sv
// Avalon-MM input PIO with synchroniser, optional debounce and per-bit
// rise/fall/level interrupt generation feeding the Nios II IRQ line.
module nios2_cpu_pio_irq_ctrl #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter logic [WIDTH-1:0] RISE_EN_RESET   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_level_en;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd;
  logic             w_wr;
  logic             w_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      assign w_stable = w_sync;
    end else begin : g_db
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0]    r_cnt [WIDTH];
      logic [WIDTH-1:0] r_stable;

      // A bit is accepted only after sync has differed from stable for D cycles in a row.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stable <= '0;
          for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] == r_stable[i]) begin
              r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_LAST) begin
              r_stable[i] <= w_sync[i];
              r_cnt[i]    <= '0;
            end else begin
              r_cnt[i] <= r_cnt[i] + CW'(1);
            end
          end
        end
      end

      assign w_stable = r_stable;
    end
  endgenerate

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_rise  = w_stable & ~r_stable_d & r_rise_en;
  assign w_fall  = ~w_stable & r_stable_d & r_fall_en;
  assign w_clr   = (w_wr && address == 3'd3) ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= '0;
      r_rise_en  <= RISE_EN_RESET;
      r_irq_mask <= '0;
      r_edge_cap <= '0;
      r_fall_en  <= '0;
      r_level_en <= '0;
    end else begin
      r_stable_d <= w_stable;
      // New edges are OR-ed in after the clear so a coincident set wins.
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_rise | w_fall;
      if (w_wr) begin
        case (address)
          3'd1:    r_rise_en  <= w_wdata;
          3'd2:    r_irq_mask <= w_wdata;
          3'd4:    r_fall_en  <= w_wdata;
          3'd5:    r_level_en <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      3'd0:    w_rd = w_stable;
      3'd1:    w_rd = r_rise_en;
      3'd2:    w_rd = r_irq_mask;
      3'd3:    w_rd = r_edge_cap;
      3'd4:    w_rd = r_fall_en;
      3'd5:    w_rd = r_level_en;
      3'd6:    w_rd = w_sync;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= 32'(w_rd);
  end

  assign irq = |(((r_edge_cap & ~r_level_en) | (w_stable & r_level_en)) & r_irq_mask);

  assign w_unused = ^writedata;

endmodule

// File: tb/tb_nios2_cpu_pio_irq_ctrl.sv
// Scenario bench: one undebounced PIO and one with DEBOUNCE_CYCLES=4 on a shared bus.
module tb_nios2_cpu_pio_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] rdata, rdata_db;
  logic [7:0]  in_port;
  logic        irq, irq_db;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  nios2_cpu_pio_irq_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata),
    .in_port(in_port), .irq(irq));

  nios2_cpu_pio_irq_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_db (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rdata_db),
    .in_port(in_port), .irq(irq_db));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input bit db, input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    d = db ? rdata_db : rdata;
  endtask

  // Pops the oldest expectation and compares it with a register read.
  task automatic rd_chk(input bit db, input logic [2:0] a, input string nm);
    logic [31:0] got, e;
    rd(db, a, got);
    e = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      $display("FAIL %s: got %h expected %h", nm, got, e);
      n_err++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    step(3);
    n_vec++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL reset_out: got rd=%h irq=%b expected 0/0", rdata, irq);
      n_err++;
    end
    reset_n = 1'b1;
    step(1);
    exp_q.push_back(32'h0);  rd_chk(0, 3'd0, "rst_data");
    exp_q.push_back(32'hFF); rd_chk(0, 3'd1, "rst_rise_en");
    exp_q.push_back(32'h0);  rd_chk(0, 3'd2, "rst_mask");
    exp_q.push_back(32'h0);  rd_chk(0, 3'd3, "rst_cap");
    exp_q.push_back(32'h0);  rd_chk(0, 3'd4, "rst_fall_en");
    exp_q.push_back(32'h0);  rd_chk(0, 3'd5, "rst_level_en");
    exp_q.push_back(32'h0);  rd_chk(0, 3'd7, "rst_addr7");
  endtask

  task automatic test_rise_irq;
    wr(3'd2, 32'h01);
    in_port[0] = 1'b1;
    step(2);
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL rise_early: got irq=%b expected 0", irq); n_err++;
    end
    step(1);
    n_vec++;
    if (irq !== 1'b1) begin
      $display("FAIL rise_irq: got irq=%b expected 1", irq); n_err++;
    end
    exp_q.push_back(32'h01); rd_chk(0, 3'd3, "rise_cap");
    wr(3'd3, 32'h01);
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL w1c_irq: got irq=%b expected 0", irq); n_err++;
    end
    exp_q.push_back(32'h00); rd_chk(0, 3'd3, "w1c_cap");
    wr(3'd0, 32'hFF);
    exp_q.push_back(32'h01); rd_chk(0, 3'd0, "ro_data");
    wr(3'd6, 32'hFF);
    exp_q.push_back(32'h01); rd_chk(0, 3'd6, "ro_sync");
    wr(3'd1, 32'hFFFF_FF5A);
    exp_q.push_back(32'h5A); rd_chk(0, 3'd1, "upper_bits");
    wr(3'd1, 32'hFF);
  endtask

  task automatic test_fall;
    wr(3'd1, 32'h00);
    wr(3'd4, 32'h04);
    in_port[2] = 1'b1;
    step(4);
    wr(3'd3, 32'hFF);
    in_port[2] = 1'b0;
    step(4);
    exp_q.push_back(32'h04); rd_chk(0, 3'd3, "fall_cap");
    wr(3'd3, 32'h04);
    in_port[2] = 1'b1;
    step(4);
    exp_q.push_back(32'h00); rd_chk(0, 3'd3, "fall_no_rise");
    wr(3'd1, 32'hFF);
    wr(3'd4, 32'h00);
  endtask

  task automatic test_debounce;
    step(10);
    wr(3'd3, 32'hFF);
    in_port[1] = 1'b1;
    step(3);
    in_port[1] = 1'b0;
    step(10);
    exp_q.push_back(32'h05); rd_chk(1, 3'd0, "db_glitch_data");
    exp_q.push_back(32'h00); rd_chk(1, 3'd3, "db_glitch_cap");
    in_port[1] = 1'b1;
    step(4);
    in_port[1] = 1'b0;
    exp_q.push_back(32'h05); rd_chk(1, 3'd0, "db_pre1");
    exp_q.push_back(32'h05); rd_chk(1, 3'd0, "db_pre2");
    exp_q.push_back(32'h07); rd_chk(1, 3'd0, "db_accept");
    step(10);
    exp_q.push_back(32'h02); rd_chk(1, 3'd3, "db_cap");
    exp_q.push_back(32'h05); rd_chk(1, 3'd0, "db_release");
  endtask

  task automatic test_set_wins;
    wr(3'd3, 32'hFF);
    in_port[3] = 1'b1;
    step(2);
    wr(3'd3, 32'h08);
    exp_q.push_back(32'h08); rd_chk(0, 3'd3, "set_wins");
    in_port[0] = 1'b0;
    step(4);
    in_port[0] = 1'b1;
    step(4);
    exp_q.push_back(32'h09); rd_chk(0, 3'd3, "cap_09");
    wr(3'd3, 32'h01);
    exp_q.push_back(32'h08); rd_chk(0, 3'd3, "w1c_bitwise");
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL masked_irq: got irq=%b expected 0", irq); n_err++;
    end
  endtask

  task automatic test_level;
    wr(3'd3, 32'hFF);
    wr(3'd5, 32'h10);
    wr(3'd2, 32'h10);
    in_port[4] = 1'b1;
    step(1);
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL level_early: got irq=%b expected 0", irq); n_err++;
    end
    step(1);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (irq !== 1'b1) begin
        $display("FAIL level_hold%0d: got irq=%b expected 1", i, irq); n_err++;
      end
      step(1);
    end
    exp_q.push_back(32'h10); rd_chk(0, 3'd3, "level_cap");
    wr(3'd3, 32'h10);
    n_vec++;
    if (irq !== 1'b1) begin
      $display("FAIL level_w1c: got irq=%b expected 1", irq); n_err++;
    end
    in_port[4] = 1'b0;
    step(1);
    n_vec++;
    if (irq !== 1'b1) begin
      $display("FAIL level_drop_early: got irq=%b expected 1", irq); n_err++;
    end
    step(2);
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL level_drop: got irq=%b expected 0", irq); n_err++;
    end
  endtask

  task automatic test_reset_mid;
    wr(3'd5, 32'h00);
    wr(3'd4, 32'hFF);
    wr(3'd2, 32'hFF);
    wr(3'd3, 32'hFF);
    in_port = ~in_port;
    step(3);
    exp_q.push_back(32'hFF); rd_chk(0, 3'd3, "all_cap");
    n_vec++;
    if (irq !== 1'b1) begin
      $display("FAIL all_irq: got irq=%b expected 1", irq); n_err++;
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (irq !== 1'b0 || irq_db !== 1'b0 || rdata !== 32'h0 || rdata_db !== 32'h0) begin
      $display("FAIL mid_reset: got irq=%b irq_db=%b rd=%h rd_db=%h expected all 0",
               irq, irq_db, rdata, rdata_db);
      n_err++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(32'h00); rd_chk(0, 3'd0, "post_rst_d1");
    exp_q.push_back(32'h00); rd_chk(0, 3'd0, "post_rst_d2");
    exp_q.push_back(32'hF2); rd_chk(0, 3'd0, "post_rst_d3");
    exp_q.push_back(32'h00); rd_chk(0, 3'd2, "post_rst_mask");
    n_vec++;
    if (irq !== 1'b0) begin
      $display("FAIL post_rst_irq: got irq=%b expected 0", irq); n_err++;
    end
    exp_q.push_back(32'h00); rd_chk(1, 3'd0, "post_rst_db_data");
    step(10);
    exp_q.push_back(32'hF2); rd_chk(0, 3'd3, "post_rst_cap");
    exp_q.push_back(32'hF2); rd_chk(1, 3'd3, "post_rst_db_cap");
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_fall();
    test_debounce();
    test_set_wins();
    test_level();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
